// File: rtl/rtp_tx_scheduler.sv
// rtp_tx_scheduler
//
// Round-robin scheduler that shares one RTP packet transmitter between
// NUM_STREAMS video stream requesters. One stream is granted at a time. The
// transmitter gets a one-cycle start pulse together with that stream's 32-bit
// extended sequence number. The scheduler then waits for packet completion
// (or a timeout) and inserts a programmable inter-packet gap.
//
// Ports:
//   clk            core clock
//   reset          synchronous, active-high reset
//   enable         allows new arbitration (IDLE -> ARB) when high
//   gap_cycles     idle cycles after each packet, sampled at packet end
//   stream_req     per-stream level request, held until granted
//   seq_clr        per-stream pulse clearing that stream's sequence counter
//   stream_grant   one-hot grant, held from START through WAIT_DONE
//   tx_start       one-cycle start pulse to the transmitter
//   tx_stream_id   index of the granted stream
//   tx_seq_nr      lower 16 bits of the granted stream's counter snapshot
//   tx_ext_seq_nr  upper 16 bits of the granted stream's counter snapshot
//   tx_done        one-cycle packet-end pulse from the transmitter
//   timeout_err    one-cycle pulse when the wait for tx_done times out
//   sched_busy     high in every state except IDLE
//
// SEQ_RESET_VAL is the value the sequence counters take on reset. It is 0 in
// normal use; a non-zero value lets counter wrap behaviour be exercised
// without sending tens of thousands of packets first.

module rtp_tx_scheduler #(
    parameter int unsigned NUM_STREAMS    = 4,
    parameter int unsigned GAP_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [31:0] SEQ_RESET_VAL  = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [GAP_WIDTH-1:0]           gap_cycles,
    input  logic [NUM_STREAMS-1:0]         stream_req,
    input  logic [NUM_STREAMS-1:0]         seq_clr,
    output logic [NUM_STREAMS-1:0]         stream_grant,
    output logic                           tx_start,
    output logic [$clog2(NUM_STREAMS)-1:0] tx_stream_id,
    output logic [15:0]                    tx_seq_nr,
    output logic [15:0]                    tx_ext_seq_nr,
    input  logic                           tx_done,
    output logic                           timeout_err,
    output logic                           sched_busy
);

    localparam int unsigned IdW = $clog2(NUM_STREAMS);
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StArb   = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [IdW-1:0]         ptr_q, ptr_d;
    logic [NUM_STREAMS-1:0] grant_q, grant_d;
    logic [IdW-1:0]         id_q, id_d;
    logic [31:0]            snap_q, snap_d;
    logic [ToW-1:0]         to_cnt_q, to_cnt_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]            seq_q [NUM_STREAMS];
    logic [31:0]            seq_d [NUM_STREAMS];

    logic                   pick_found;
    logic [IdW-1:0]         pick_idx;
    logic [IdW-1:0]         cand;
    logic                   timeout_hit;
    logic                   done_inc;

    // Round-robin pick: first requester strictly after the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_STREAMS; k++) begin
            cand = IdW'((32'(ptr_q) + k) % NUM_STREAMS);
            if (!pick_found && stream_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // tx_done takes priority over a timeout landing in the same cycle.
    assign timeout_hit = (state_q == StWait) && !tx_done && (to_cnt_q == ToW'(TIMEOUT_CYCLES));
    assign done_inc    = (state_q == StWait) && tx_done;

    // Per-stream sequence counters; a clear beats a coincident increment.
    always_comb begin
        for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            seq_d[i] = seq_q[i];
            if (done_inc && (id_q == IdW'(i))) begin
                seq_d[i] = seq_q[i] + 32'd1;
            end
            if (seq_clr[i]) begin
                seq_d[i] = '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        id_d      = id_q;
        snap_d    = snap_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            StIdle: begin
                if (enable && (stream_req != '0)) begin
                    state_d = StArb;
                end
            end

            StArb: begin
                if (pick_found) begin
                    state_d = StStart;
                    ptr_d   = pick_idx;
                    id_d    = pick_idx;
                    grant_d = NUM_STREAMS'(1) << pick_idx;
                    // Snapshot is taken here; later clears do not touch it.
                    snap_d  = seq_q[pick_idx];
                end else begin
                    state_d = StIdle;
                end
            end

            StStart: begin
                state_d  = StWait;
                to_cnt_d = '0;
            end

            StWait: begin
                if (tx_done || timeout_hit) begin
                    state_d   = StGap;
                    grant_d   = '0;
                    gap_cnt_d = gap_cycles;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end

            StGap: begin
                // GAP lasts max(gap_cycles, 1) cycles.
                if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= IdW'(NUM_STREAMS - 1);
            grant_q   <= '0;
            id_q      <= '0;
            snap_q    <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                seq_q[i] <= SEQ_RESET_VAL;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            snap_q    <= snap_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                seq_q[i] <= seq_d[i];
            end
        end
    end

    assign stream_grant  = grant_q;
    assign tx_start      = (state_q == StStart);
    assign tx_stream_id  = id_q;
    assign tx_seq_nr     = snap_q[15:0];
    assign tx_ext_seq_nr = snap_q[31:16];
    assign timeout_err   = timeout_hit;
    assign sched_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_rtp_tx_scheduler.sv
// Directed bench for rtp_tx_scheduler. Three instances share all inputs:
// dut (counters reset to 0), dut_b (counters reset to 0x0000FFFF) and
// dut_c (counters reset to 0xFFFFFFFF), all with a 20-cycle timeout.
module tb_rtp_tx_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] gap_cycles;
    logic [3:0]  stream_req;
    logic [3:0]  seq_clr;
    logic        tx_done;

    logic [3:0]  grant, b_grant, c_grant;
    logic        start, b_start, c_start;
    logic [1:0]  id, b_id, c_id;
    logic [15:0] seq, b_seq, c_seq;
    logic [15:0] ext, b_ext, c_ext;
    logic        terr, b_terr, c_terr;
    logic        busy, b_busy, c_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    rtp_tx_scheduler #(.NUM_STREAMS(4), .GAP_WIDTH(16), .TIMEOUT_CYCLES(20),
                       .SEQ_RESET_VAL(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .enable(enable), .gap_cycles(gap_cycles),
        .stream_req(stream_req), .seq_clr(seq_clr), .stream_grant(grant),
        .tx_start(start), .tx_stream_id(id), .tx_seq_nr(seq), .tx_ext_seq_nr(ext),
        .tx_done(tx_done), .timeout_err(terr), .sched_busy(busy)
    );

    rtp_tx_scheduler #(.NUM_STREAMS(4), .GAP_WIDTH(16), .TIMEOUT_CYCLES(20),
                       .SEQ_RESET_VAL(32'h0000_FFFF)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .gap_cycles(gap_cycles),
        .stream_req(stream_req), .seq_clr(seq_clr), .stream_grant(b_grant),
        .tx_start(b_start), .tx_stream_id(b_id), .tx_seq_nr(b_seq), .tx_ext_seq_nr(b_ext),
        .tx_done(tx_done), .timeout_err(b_terr), .sched_busy(b_busy)
    );

    rtp_tx_scheduler #(.NUM_STREAMS(4), .GAP_WIDTH(16), .TIMEOUT_CYCLES(20),
                       .SEQ_RESET_VAL(32'hFFFF_FFFF)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .gap_cycles(gap_cycles),
        .stream_req(stream_req), .seq_clr(seq_clr), .stream_grant(c_grant),
        .tx_start(c_start), .tx_stream_id(c_id), .tx_seq_nr(c_seq), .tx_ext_seq_nr(c_ext),
        .tx_done(tx_done), .timeout_err(c_terr), .sched_busy(c_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Tick until tx_start is seen (bounded); returns cycles waited.
    task automatic wait_start(input string tag, output int cycles);
        cycles = 0;
        while (start !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        check({tag, "_start_seen"}, 32'(start), 32'd1);
    endtask

    // Called in the START cycle; tx_done is high in the len-th WAIT_DONE cycle.
    task automatic finish_packet(input int len);
        repeat (len) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        gap_cycles = 16'd0;
        stream_req = 4'b0000;
        seq_clr    = 4'b0000;
        tx_done    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset values
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_start", 32'(start), 32'h0);
        check("rst_id",    32'(id),    32'h0);
        check("rst_seq",   32'(seq),   32'h0);
        check("rst_ext",   32'(ext),   32'h0);
        check("rst_terr",  32'(terr),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);

        // 1: single requester, start two cycles after request
        enable     = 1'b1;
        stream_req = 4'b0001;
        wait_start("t1a", cyc);
        check("t1_latency", 32'(cyc),   32'd2);
        check("t1_grant",   32'(grant), 32'h1);
        check("t1_seq0",    32'(seq),   32'h0);
        finish_packet(10);
        check("t1_gap_grant", 32'(grant), 32'h0);
        check("t1_gap_busy",  32'(busy),  32'h1);
        wait_start("t1b", cyc);
        check("t1_seq1",    32'(seq),   32'h1);
        check("t1_grant2",  32'(grant), 32'h1);
        finish_packet(10);

        // 2/3: four streams round-robin; wrap instances ride along
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        stream_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_start("t2", cyc);
            check("t2_id",    32'(id),    32'(k % 4));
            check("t2_grant", 32'(grant), 32'h1 << (k % 4));
            check("t2_seq",   32'(seq),   32'(k / 4));
            check("t2_ext",   32'(ext),   32'h0);
            if (k == 2) begin
                check("t3_b_pre", {b_ext, b_seq}, 32'h0000_FFFF);
                check("t3_c_pre", {c_ext, c_seq}, 32'hFFFF_FFFF);
            end
            if (k == 6) begin
                check("t3_b_ext", 32'(b_ext), 32'h0001);
                check("t3_b_seq", 32'(b_seq), 32'h0000);
                check("t3_c_wrap", {c_ext, c_seq}, 32'h0000_0000);
            end
            finish_packet(3);
        end
        stream_req = 4'b0000;

        // 4: timeout on stream 1 (counter 2)
        stream_req = 4'b0010;
        wait_start("t4a", cyc);
        check("t4_seq_before", 32'(seq), 32'h2);
        tick();
        cyc = 0;
        while (terr !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t4_timeout_delay", 32'(cyc),   32'd20);
        check("t4_grant_at_to",   32'(grant), 32'h2);
        tick();
        check("t4_grant_drop", 32'(grant), 32'h0);
        check("t4_terr_pulse", 32'(terr),  32'h0);
        wait_start("t4b", cyc);
        check("t4_seq_unchanged", 32'(seq), 32'h2);
        finish_packet(4);

        // 5: bring stream 1 to 5, then clear coinciding with tx_done; gap of 7
        wait_start("t5a", cyc);
        finish_packet(4);
        wait_start("t5b", cyc);
        finish_packet(4);
        wait_start("t5c", cyc);
        check("t5_seq5", 32'(seq), 32'h5);
        repeat (3) tick();
        gap_cycles = 16'd7;
        tx_done    = 1'b1;
        seq_clr    = 4'b0010;
        tick();
        tx_done    = 1'b0;
        seq_clr    = 4'b0000;
        gap_cycles = 16'd0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            tick();
        end
        check("t5_gap_len", 32'(cyc), 32'd7);
        wait_start("t5d", cyc);
        check("t5_seq_cleared", 32'(seq), 32'h0);

        // 6: enable dropped mid-packet; stray tx_done in IDLE; reset mid-wait
        enable = 1'b0;
        finish_packet(5);
        check("t6_gap_busy", 32'(busy), 32'h1);
        repeat (5) tick();
        check("t6_idle_busy",  32'(busy),  32'h0);
        check("t6_idle_start", 32'(start), 32'h0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("t6_still_idle", 32'(busy), 32'h0);
        enable = 1'b1;
        wait_start("t6a", cyc);
        check("t6_seq1", 32'(seq), 32'h1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_busy",  32'(busy),  32'h0);
        check("t6_rst_start", 32'(start), 32'h0);
        reset      = 1'b0;
        stream_req = 4'b0011;
        wait_start("t6b", cyc);
        check("t6_id0",   32'(id),  32'h0);
        check("t6_s0seq", 32'(seq), 32'h0);
        finish_packet(3);
        wait_start("t6c", cyc);
        check("t6_id1",   32'(id),  32'h1);
        check("t6_s1seq", 32'(seq), 32'h0);
        finish_packet(3);
        stream_req = 4'b0000;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtp_tx_scheduler.md
Name: rtp_tx_scheduler

Overview:
- Round-robin scheduler that shares the single RTP packet transmitter between NUM_STREAMS video stream requesters.
- Grants one stream at a time and issues a one-cycle start to the transmitter, presenting that stream's 32-bit extended sequence number (upper half = payload-header extended sequence, lower half = RTP header sequence).
- Waits for packet completion, then enforces a programmable inter-packet gap.
- Sits between the per-stream video framers and the RTP transmit FSM.

Parameters:
- NUM_STREAMS, 4, number of requesting streams (2..16).
- GAP_WIDTH, 16, width of the inter-packet gap counter.
- TIMEOUT_CYCLES, 65535, maximum cycles to wait for tx_done before aborting the grant.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  allows new arbitration when high.
- gap_cycles  input  GAP_WIDTH  idle cycles inserted after each packet; sampled at packet end.
- stream_req  input  NUM_STREAMS  per-stream level request; held until granted.
- seq_clr  input  NUM_STREAMS  per-stream pulse that clears the sequence counter to 0.
- stream_grant  output  NUM_STREAMS  one-hot grant, held from START through WAIT_DONE.
- tx_start  output  1  one-cycle pulse to the transmitter.
- tx_stream_id  output  $clog2(NUM_STREAMS)  index of the granted stream, valid while grant is held.
- tx_seq_nr  output  16  lower 16 bits of the granted stream's counter.
- tx_ext_seq_nr  output  16  upper 16 bits of the granted stream's counter.
- tx_done  input  1  one-cycle pulse from the transmitter at packet end.
- timeout_err  output  1  one-cycle pulse when the wait for tx_done times out.
- sched_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - stream_grant = 0; tx_start = 0; tx_stream_id = 0.
  - tx_seq_nr = 0; tx_ext_seq_nr = 0.
  - timeout_err = 0; sched_busy = 0.
  - All sequence counters = 0.
  - Round-robin pointer = NUM_STREAMS-1, so stream 0 wins first.
- States: IDLE, ARB, START, WAIT_DONE, GAP.
- IDLE -> ARB when enable=1 and stream_req != 0.
- ARB (1 cycle):
  - Select the first requesting stream strictly after the pointer, wrapping modulo NUM_STREAMS.
  - Register grant, id and the 32-bit counter value.
  - Update the pointer to the selected index.
  - -> START.
  - If the request dropped during ARB (stream_req == 0), return to IDLE with no grant.
- START (1 cycle):
  - tx_start=1; grant, id and sequence outputs valid. -> WAIT_DONE.
  - Start-to-grant latency from request in IDLE: 2 cycles (IDLE->ARB, ARB->START).
- WAIT_DONE:
  - Grant held. Timeout counter increments each cycle.
  - On tx_done: increment the granted stream's counter by 1 (32-bit wrap, 0xFFFFFFFF -> 0x00000000), drop grant, load the gap counter with gap_cycles, -> GAP.
  - When the timeout counter reaches TIMEOUT_CYCLES without tx_done: pulse timeout_err, drop grant, do not increment the counter, -> GAP.
- GAP:
  - Count down to 0, then -> IDLE.
  - gap_cycles=0: GAP lasts exactly 1 cycle.
- tx_done outside WAIT_DONE is ignored.
- seq_clr[i] takes effect the next cycle in any state. If it coincides with the increment of the same stream, the clear wins (result 0).
- An ARB snapshot already taken is not altered by a later seq_clr.
- enable low mid-packet: the current packet completes, including GAP. Only the IDLE->ARB transition is blocked.
- Reset asserted in any state returns to reset values on the next clock edge. Counters clear; no tx_start is issued.
- Single requester: granted back-to-back, spaced by 2 + packet + gap cycles.

Test Plan:
1. After reset, stream_req=0001, gap_cycles=0, tx_done 10 cycles after tx_start -> tx_start 2 cycles after the request, grant=0001, tx_seq_nr=0; next grant of stream 0 shows tx_seq_nr=1.
2. stream_req=1111 held, 8 packets -> grant order 0,1,2,3,0,1,2,3; each stream's tx_seq_nr goes 0 then 1.
3. Preload stream 2 to 0x0000FFFF via 65535 packets (or a forced counter) and send one more -> next tx_ext_seq_nr=0x0001, tx_seq_nr=0x0000. At 0xFFFFFFFF, the next value is 0x00000000.
4. TIMEOUT_CYCLES=20 override, no tx_done -> timeout_err pulses 20 cycles after WAIT_DONE entry, grant drops, the stream's counter is unchanged on its next grant.
5. seq_clr[1] in the same cycle as tx_done for stream 1 (counter 5) -> stream 1's next tx_seq_nr=0. gap_cycles=7 -> 7 cycles of sched_busy=1 in GAP before the next ARB.
6. enable dropped during WAIT_DONE -> the packet completes and GAP runs, then the block stays in IDLE with sched_busy=0. Reset pulsed during WAIT_DONE -> grant=0 the next cycle, all counters 0.
